alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the CPU's combinational 8-bit ALU.
- Executes the four existing ops plus the previously reserved SELECT codes: shifts and multiply. The shifts and the multiply are multi-cycle iterative units.
- Sits between the register file and the writeback mux.
- The control unit issues ops with a START/BUSY/DONE handshake and stalls the PC while BUSY is high.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from DATA2; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request: sample DATA1, DATA2, SELECT.
- DATA1  in  WIDTH  operand 1.
- DATA2  in  WIDTH  operand 2, or shift amount in DATA2[SHW-1:0].
- SELECT  in  3  opcode.
- RESULT  out  WIDTH  registered result.
- ZERO  out  1  registered; 1 when RESULT == 0.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse; RESULT/ZERO/ERROR are updated in the same edge.
- ERROR  out  1  registered; 1 when the last op was the reserved opcode.

Behaviour:
- Reset: any edge with RESET=1 forces state IDLE and RESULT=0, ZERO=1, BUSY=0, DONE=0, ERROR=0. It also clears the internal counters and operand latches. RESET has priority over START.
- Reset mid-operation: the op is aborted with no DONE and no result update.
- States:
  - IDLE: START=1 latches DATA1, DATA2 and SELECT into internal registers, loads the cycle counter with L, and moves to EXEC.
  - EXEC: BUSY=1; one step per cycle; the counter decrements.
  - Leaving EXEC: on the edge where the counter reaches 0, write RESULT/ZERO/ERROR, set DONE=1 for that cycle, return to IDLE.
- Timing: START sampled at edge E0 gives BUSY=1 for exactly L cycles, and DONE=1 in the cycle after edge E0+L.
- Back-to-back ops: START sampled while DONE=1 is accepted (the state is IDLE).
- START while BUSY=1: ignored, with no effect on the in-flight op.
- Input changes during BUSY: no effect, because the operands are latched.
- DONE is never high in two consecutive cycles unless a new op with L=1 was accepted.
- BUSY and DONE are never high together.
- Opcodes and latency L:
  - 000 FWD: RESULT=DATA2 (move/loadi). L=1.
  - 001 ADD: RESULT=(DATA1+DATA2) mod 2^WIDTH; carry discarded; SUB is done by the control unit supplying the two's complement. L=2.
  - 010 AND: bitwise. L=1.
  - 011 OR: bitwise. L=1.
  - 100 SLL: logical shift left of DATA1 by amt=DATA2[SHW-1:0], one bit per cycle, zero fill. L=max(1,amt). amt=0 gives RESULT=DATA1.
  - 101 SRA: arithmetic shift right of DATA1 by amt, sign bit replicated, one bit per cycle. L=max(1,amt).
  - 110 MUL: unsigned shift-add multiply, one multiplier bit per cycle, LSB first. RESULT = low WIDTH bits of the product; high bits are discarded. L=WIDTH, independent of operand values.
  - 111 reserved: RESULT=0, ZERO=1, ERROR=1. L=1.
- ERROR is cleared by the DONE of any non-reserved op.
- Upper DATA2 bits above SHW are ignored for shifts.
- ZERO is computed from the final RESULT value, never from intermediate shift/multiply values.
- RESULT holds its value between DONE pulses; intermediate values are never visible on RESULT.

Test Plan (WIDTH=8):
- ADD 0x7F+0x81 with START at E0 -> BUSY for 2 cycles; at E0+2 DONE=1, RESULT=0x00, ZERO=1, ERROR=0.
- MUL 13×11, then MUL 0x10×0x20 issued in the DONE cycle -> first DONE at E0+8 with RESULT=0x8F, ZERO=0; second accepted back-to-back, giving RESULT=0x00, ZERO=1 after 8 more cycles.
- SRA 0x90 by DATA2=0xF3 (amt=3, upper bits ignored) -> L=3, RESULT=0xF2. SLL 0x81 by 0 -> L=1, RESULT=0x81.
- SELECT=111 -> L=1, DONE with RESULT=0, ZERO=1, ERROR=1. A following AND 0xF0&0x3C -> RESULT=0x30, ERROR=0.
- MUL in flight; START with ADD and changed DATA1 at cycle 3 of BUSY -> ignored; MUL result unaffected, single DONE at E0+8.
- MUL in flight; RESET=1 at cycle 4 -> next cycle RESULT=0, ZERO=1, BUSY=0, no DONE ever; a new FWD 0x5A after reset -> RESULT=0x5A after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : clocked, parametrised ALU with a start/busy/done handshake.
//
// It executes the four single-step ops (FWD, ADD, AND, OR), plus iterative
// shift-left-logical, shift-right-arithmetic and shift-add multiply. The
// control unit raises start for one cycle and stalls while busy is high.
// result, zero and error change only on the edge that raises done.
//
// Parameters
//   WIDTH  : operand/result width, a power of two and at least 2
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; aborts any op in flight
//   start   in   request; data1/data2/select are sampled while idle
//   data1   in   operand 1 (value to shift, multiplicand)
//   data2   in   operand 2, or the shift amount in its low SHW bits
//   select  in   opcode
//   result  out  registered result
//   zero    out  registered, high when result is zero
//   busy    out  high while an op is executing
//   done    out  one-cycle pulse on the cycle the result is updated
//   error   out  registered, high when the last op used the reserved code
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } stateT;

    stateT            state, stateNext;
    logic [CW-1:0]    cnt, cntNext;
    logic [2:0]       opReg, opNext;
    logic [WIDTH-1:0] aReg, aNext;
    logic [WIDTH-1:0] bReg, bNext;
    logic [WIDTH-1:0] accReg, accNext;
    logic [WIDTH-1:0] resultNext;
    logic             zeroNext, errorNext, doneNext;
    logic [WIDTH-1:0] stepVal;
    logic [WIDTH-1:0] finalVal;
    logic [CW-1:0]    startLat;

    // One iteration of the iterative units. A shift by zero still spends
    // one cycle in EXEC, so the step is suppressed when the latched amount
    // is zero and the accumulator keeps the unshifted operand. The multiply
    // adds the shifted multiplicand whenever the current multiplier LSB is 1.
    always_comb begin
        stepVal = accReg;
        case (opReg)
            OP_SLL: begin
                if (bReg[SHW-1:0] != '0) begin
                    stepVal = accReg << 1;
                end
            end
            OP_SRA: begin
                if (bReg[SHW-1:0] != '0) begin
                    stepVal = {accReg[WIDTH-1], accReg[WIDTH-1:1]};
                end
            end
            OP_MUL: begin
                if (bReg[0]) begin
                    stepVal = accReg + aReg;
                end
            end
            default: begin
                stepVal = accReg;
            end
        endcase
    end

    // The value written to result on the finishing edge. The iterative ops
    // take the accumulator after its last step; the reserved code yields 0.
    always_comb begin
        finalVal = '0;
        case (opReg)
            OP_FWD:                 finalVal = bReg;
            OP_ADD:                 finalVal = aReg + bReg;
            OP_AND:                 finalVal = aReg & bReg;
            OP_OR:                  finalVal = aReg | bReg;
            OP_SLL, OP_SRA, OP_MUL: finalVal = stepVal;
            default:                finalVal = '0;
        endcase
    end

    // Cycle count for a newly requested op. ADD takes two cycles, the
    // multiply one per multiplier bit, a shift one per bit position moved
    // (a shift by zero still takes one), and everything else a single cycle.
    always_comb begin
        startLat = CW'(1);
        case (select)
            OP_ADD: startLat = CW'(2);
            OP_SLL, OP_SRA: begin
                if (data2[SHW-1:0] != '0) begin
                    startLat = {1'b0, data2[SHW-1:0]};
                end
            end
            OP_MUL: startLat = CW'(WIDTH);
            default: startLat = CW'(1);
        endcase
    end

    // Next-state and output logic. In IDLE a start latches the operands and
    // loads the counter. In EXEC the counter steps down once per cycle, and
    // the cycle where it holds 1 is the last: that edge returns to IDLE and
    // publishes result/zero/error together with the done pulse.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        opNext     = opReg;
        aNext      = aReg;
        bNext      = bReg;
        accNext    = accReg;
        resultNext = result;
        zeroNext   = zero;
        errorNext  = error;
        doneNext   = 1'b0;
        busy       = (state == EXEC);
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = EXEC;
                    opNext    = select;
                    aNext     = data1;
                    bNext     = data2;
                    accNext   = (select == OP_MUL) ? '0 : data1;
                    cntNext   = startLat;
                end
            end
            EXEC: begin
                accNext = stepVal;
                if (opReg == OP_MUL) begin
                    aNext = aReg << 1;
                    bNext = bReg >> 1;
                end
                cntNext = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    stateNext  = IDLE;
                    resultNext = finalVal;
                    zeroNext   = (finalVal == '0);
                    errorNext  = (opReg == 3'b111);
                    doneNext   = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over everything else and
    // throws away an op in flight without pulsing done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            accReg <= '0;
            result <= '0;
            zero   <= 1'b1;
            error  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            opReg  <= opNext;
            aReg   <= aNext;
            bReg   <= bNext;
            accReg <= accNext;
            result <= resultNext;
            zero   <= zeroNext;
            error  <= errorNext;
            done   <= doneNext;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq at WIDTH=8.
//
// A table of vectors is issued back to back, each new op starting in the
// done cycle of the previous one. Expected values go into a scoreboard
// queue when an op is driven and are popped when done appears. Hand-written
// sequences cover start while busy and reset in the middle of a multiply.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] select;
    logic [7:0] result;
    logic       zero;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic       zero;
        logic       err;
        int         lat;
    } vecT;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       err;
        int         lat;
    } expT;

    expT sb[$];
    vecT vecs[14];

    alu_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data1  (data1),
        .data2  (data2),
        .select (select),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a FAIL line on disagreement.
    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one request for exactly one edge, then scramble the operands so
    // that any failure to latch them shows up in the result.
    task automatic driveOp(input logic [2:0] sel, input logic [7:0] d1,
                           input logic [7:0] d2);
        start  = 1'b1;
        select = sel;
        data1  = d1;
        data2  = d2;
        @(posedge clk);
        #1;
        start  = 1'b0;
        select = 3'($urandom);
        data1  = 8'($urandom);
        data2  = 8'($urandom);
    endtask

    // Queue the expected outcome, then issue the op.
    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] eRes,
                                 input logic eZero, input logic eErr,
                                 input int eLat);
        expT e;
        e.res  = eRes;
        e.zero = eZero;
        e.err  = eErr;
        e.lat  = eLat;
        sb.push_back(e);
        driveOp(sel, d1, d2);
    endtask

    // Wait (bounded) for done, counting edges and busy cycles since the
    // start edge, then pop the scoreboard and compare. startCount is the
    // number of cycles the caller already spent after the start edge.
    task automatic checkOutput(input int startCount, input string tag);
        int  lat;
        int  busyCnt;
        expT e;
        lat     = startCount;
        busyCnt = startCount;
        while (!done && lat < 64) begin
            if (busy) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) begin
            cmp({tag, ".scoreboard"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!done) begin
            cmp({tag, ".doneTimeout"}, 0, 1);
        end else begin
            cmp({tag, ".result"}, int'(result), int'(e.res));
            cmp({tag, ".zero"}, int'(zero), int'(e.zero));
            cmp({tag, ".error"}, int'(error), int'(e.err));
            cmp({tag, ".latency"}, lat, e.lat);
            cmp({tag, ".busyCycles"}, busyCnt, e.lat);
            cmp({tag, ".busyWithDone"}, int'(busy), 0);
        end
    endtask

    // Main test sequence.
    initial begin
        int extra;
        vecs[0]  = '{3'b001, 8'h7F, 8'h81, 8'h00, 1'b1, 1'b0, 2};
        vecs[1]  = '{3'b110, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8};
        vecs[2]  = '{3'b110, 8'h10, 8'h20, 8'h00, 1'b1, 1'b0, 8};
        vecs[3]  = '{3'b101, 8'h90, 8'hF3, 8'hF2, 1'b0, 1'b0, 3};
        vecs[4]  = '{3'b100, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1};
        vecs[5]  = '{3'b111, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1};
        vecs[6]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b000, 8'h12, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b011, 8'h0F, 8'h50, 8'h5F, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b100, 8'h03, 8'h07, 8'h80, 1'b0, 1'b0, 7};
        vecs[10] = '{3'b101, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, 2};
        vecs[11] = '{3'b001, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 2};
        vecs[12] = '{3'b101, 8'h81, 8'hF8, 8'h81, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b110, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 8};

        reset  = 1'b1;
        start  = 1'b0;
        data1  = 8'h00;
        data2  = 8'h00;
        select = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.result", int'(result), 0);
        cmp("reset.zero", int'(zero), 1);
        cmp("reset.busy", int'(busy), 0);
        cmp("reset.done", int'(done), 0);
        cmp("reset.error", int'(error), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].d1, vecs[i].d2, vecs[i].res,
                          vecs[i].zero, vecs[i].err, vecs[i].lat);
            checkOutput(0, $sformatf("vec%0d", i));
        end
        @(posedge clk);
        #1;
        cmp("idle.doneLow", int'(done), 0);

        $display("[TB] start while busy");
        applyStimulus(3'b110, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start  = 1'b1;
        select = 3'b001;
        data1  = 8'h55;
        data2  = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput(3, "ignore");
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        cmp("ignore.extraDone", extra, 0);

        $display("[TB] reset during multiply");
        driveOp(3'b110, 8'h0D, 8'h0B);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cmp("midReset.result", int'(result), 0);
        cmp("midReset.zero", int'(zero), 1);
        cmp("midReset.busy", int'(busy), 0);
        cmp("midReset.done", int'(done), 0);
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        cmp("midReset.noDone", extra, 0);
        applyStimulus(3'b000, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1);
        checkOutput(0, "postReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
